// File: rtl/crc_stream_checker.sv
// Serial MSB-first Galois CRC engine with a frame-level valid/ready input,
// programmable residue check and saturating match/mismatch counters.
module crc_stream_checker #(
  parameter int                CRC_W  = 8,
  parameter logic [CRC_W-1:0]  POLY   = 'h07,
  parameter logic [CRC_W-1:0]  INIT   = '0,
  parameter int                DATA_W = 8,
  parameter int                CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              d_valid,
  input  logic              d_last,
  output logic              d_ready,
  input  logic [CRC_W-1:0]  residue,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_match,
  output logic [CNT_W-1:0]  ctr,
  output logic [CNT_W-1:0]  err_ctr
);

  localparam int              CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CRC_W-1:0]    lfsr;
  logic [CRC_W-1:0]    lfsr_step;
  logic [CRC_W-1:0]    crc_q;
  logic [DATA_W-1:0]   shreg;
  logic [CW-1:0]       bit_cnt;
  logic                last_q;
  logic                in_frame;
  logic                match_q;
  logic                fb;
  logic                lfsr_match;

  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = last_q ? DONE : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign d_ready    = (state == IDLE);
  assign fb         = lfsr[CRC_W-1] ^ shreg[DATA_W-1];
  assign lfsr_step  = (lfsr << 1) ^ (fb ? POLY : '0);
  assign lfsr_match = (lfsr == residue);

  // During DONE the live LFSR and comparison are presented so the pulse and
  // the new result coincide; the registered copies hold them afterwards.
  assign crc_valid = (state == DONE);
  assign crc_out   = crc_valid ? lfsr : crc_q;
  assign crc_match = crc_valid ? lfsr_match : match_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr     <= INIT;
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
      crc_q    <= '0;
      match_q  <= 1'b0;
      ctr      <= '0;
      err_ctr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            shreg   <= din;
            last_q  <= d_last;
            bit_cnt <= '0;
            if (!in_frame) begin
              lfsr     <= INIT;
              in_frame <= 1'b1;
            end
          end
        end
        SHIFT: begin
          lfsr    <= lfsr_step;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
        DONE: begin
          crc_q    <= lfsr;
          match_q  <= lfsr_match;
          in_frame <= 1'b0;
          if (lfsr_match) begin
            if (ctr != CNT_MAX) ctr <= ctr + CNT_W'(1);
          end else begin
            if (err_ctr != CNT_MAX) err_ctr <= err_ctr + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
